// File: rtl/cache_pkg.sv
// Shared types for the 2-way set-associative, write-through cache controller.
package cache_pkg;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 28;
  localparam int IDX_W  = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } line_t;
endpackage

// File: rtl/cache_way.sv
// One cache way: valid/tag/data per set, combinational read, clocked write.
module cache_way
  import cache_pkg::*;
#(
  parameter int SET_WIDTH = IDX_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SET_WIDTH-1:0] rd_idx,
  output logic                 rd_valid,
  output logic [TAG_W-1:0]     rd_tag,
  output logic [DATA_W-1:0]    rd_data,
  input  logic                 wr_en,
  input  logic [SET_WIDTH-1:0] wr_idx,
  input  logic [TAG_W-1:0]     wr_tag,
  input  logic [DATA_W-1:0]    wr_data
);
  localparam int SETS = 1 << SET_WIDTH;

  logic [SETS-1:0]   valid;
  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [DATA_W-1:0] data_mem [SETS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tag and data contents are meaningless while valid is clear, so no reset here.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];
endmodule

// File: rtl/cache_ctrl.sv
// 2-way set-associative write-through, no-write-allocate cache controller
// with one LRU bit per set and a single outstanding memory transaction.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SET_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [DATA_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ready,
  output logic                  hit,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic [1:0]            dbg_state
);
  localparam int SETS = 1 << SET_WIDTH;

  // Handshakes: a CPU access is a request held stable until the cycle with
  // cpu_ready=1; a memory access is mem_req held until the one-cycle mem_ack.
  state_t                  state;
  logic [DATA_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic                    victim;
  logic [SETS-1:0]         lru;

  logic [SET_WIDTH-1:0]    cur_idx, req_idx, acc_idx;
  logic [TAG_W-1:0]        cur_tag, req_tag, acc_tag;
  logic [DATA_W-1:0]       acc_data;
  logic [1:0]              wr_en;
  logic                    acc_way, lru_upd, victim_nx;

  logic [1:0]              way_valid;
  logic [TAG_W-1:0]        way_tag  [2];
  logic [DATA_W-1:0]       way_data [2];
  line_t                   line     [2];
  logic [1:0]              match;

  assign cur_idx = cpu_addr[SET_WIDTH+1:2];
  assign cur_tag = cpu_addr[DATA_WIDTH-1 -: TAG_W];
  assign req_idx = req_addr[SET_WIDTH+1:2];
  assign req_tag = req_addr[DATA_WIDTH-1 -: TAG_W];

  for (genvar w = 0; w < 2; w++) begin : g_way
    cache_way #(.SET_WIDTH(SET_WIDTH)) u_way (
      .clk      (clk),
      .rst      (rst),
      .rd_idx   (cur_idx),
      .rd_valid (way_valid[w]),
      .rd_tag   (way_tag[w]),
      .rd_data  (way_data[w]),
      .wr_en    (wr_en[w]),
      .wr_idx   (acc_idx),
      .wr_tag   (acc_tag),
      .wr_data  (acc_data)
    );
    assign line[w]  = '{valid: way_valid[w], tag: way_tag[w], data: way_data[w]};
    assign match[w] = line[w].valid && (line[w].tag == cur_tag);
  end

  // Way 1 wins when both ways match.
  assign hit       = |match;
  assign victim_nx = !line[0].valid ? 1'b0 : (!line[1].valid ? 1'b1 : lru[cur_idx]);

  always_comb begin
    wr_en    = 2'b00;
    lru_upd  = 1'b0;
    acc_idx  = cur_idx;
    acc_tag  = cur_tag;
    acc_data = cpu_wdata;
    acc_way  = match[1];
    case (state)
      IDLE: begin
        if (cpu_req && hit) begin
          lru_upd = 1'b1;
          if (cpu_we) wr_en = match[1] ? 2'b10 : 2'b01;
        end
      end
      REFILL: begin
        acc_idx  = req_idx;
        acc_tag  = req_tag;
        acc_data = mem_rdata;
        acc_way  = victim;
        if (mem_ack) begin
          lru_upd = 1'b1;
          wr_en   = victim ? 2'b10 : 2'b01;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lru       <= '0;
      req_addr  <= '0;
      req_wdata <= '0;
      victim    <= 1'b0;
    end else begin
      if (lru_upd) lru[acc_idx] <= ~acc_way;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            req_addr  <= cpu_addr;
            req_wdata <= cpu_wdata;
            victim    <= victim_nx;
            if (cpu_we)    state <= WRITE;
            else if (!hit) state <= REFILL;
          end
        end
        REFILL, WRITE: if (mem_ack) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory-side outputs decode straight from state so reset drops them at once.
  always_comb begin
    cpu_ready = 1'b0;
    cpu_rdata = match[1] ? line[1].data : line[0].data;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    case (state)
      IDLE:   cpu_ready = cpu_req && !cpu_we && hit;
      REFILL: begin
        mem_req   = 1'b1;
        cpu_ready = mem_ack;
        cpu_rdata = mem_rdata;
      end
      WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        cpu_ready = mem_ack;
      end
      default: ;
    endcase
  end

  assign mem_addr  = req_addr & ~DATA_WIDTH'(3);
  assign mem_wdata = req_wdata;
  assign dbg_state = state;
endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: access table plus hand sequences, with a memory model
// acting as main memory and a read-data scoreboard.
module tb_cache_ctrl;
  import cache_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_req, cpu_we;
  logic [W-1:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic         cpu_ready, hit;
  logic         mem_req, mem_we;
  logic [W-1:0] mem_addr, mem_wdata, mem_rdata;
  logic         mem_ack;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  cache_ctrl #(.DATA_WIDTH(W), .SET_WIDTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .hit       (hit),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .dbg_state (dbg_state)
  );

  typedef struct {
    logic         we;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
    int           dly;
    logic         exp_hit;
    int           drop;
  } vec_t;

  vec_t         vecs[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mem_m [logic [W-1:0]];
  int           n_tests = 0;
  int           n_fail  = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mem_val(input logic [W-1:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic add(input logic we, input logic [W-1:0] addr, input logic [W-1:0] wdata,
                     input int dly, input logic exp_hit, input int drop);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.dly = dly; v.exp_hit = exp_hit; v.drop = drop;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic access(input vec_t v);
    logic [W-1:0] a;
    int   cyc, n_mem, ready_cyc, target, exp_cyc;
    logic done;
    a = v.addr & ~32'h3;
    cyc = 0; n_mem = 0; ready_cyc = -1; done = 1'b0;
    target  = (v.dly < 1) ? 1 : v.dly;
    exp_cyc = (!v.we && v.exp_hit) ? 0 : v.dly;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata; mem_ack = 1'b0;
    if (!v.we) exp_q.push_back(mem_val(a));
    while (!done && cyc < 40) begin
      if (v.drop != 0 && cyc == v.drop) cpu_req = 1'b0;
      if (mem_req) begin
        n_mem++;
        mem_ack   = (n_mem == target);
        mem_rdata = mem_val(a);
      end else begin
        mem_ack = 1'b0;
      end
      @(negedge clk);
      if (cyc == 0) check("hit", 32'(hit), 32'(v.exp_hit));
      if (mem_req) begin
        check("mem_we", 32'(mem_we), 32'(v.we));
        check("mem_addr", mem_addr, a);
        if (v.we) check("mem_wdata", mem_wdata, v.wdata);
      end
      if (cpu_ready) begin
        done = 1'b1;
        ready_cyc = cyc;
        if (!v.we) begin
          if (exp_q.size() == 0) check("sb_empty", 32'(exp_q.size()), 32'd1);
          else                   check("rdata", cpu_rdata, exp_q.pop_front());
        end
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    check("done", 32'(done), 32'd1);
    if (done) begin
      check("ready_cyc", 32'(ready_cyc), 32'(exp_cyc));
      check("mem_cycles", 32'(n_mem), 32'(exp_cyc));
      if (v.we) mem_m[a] = v.wdata;
      @(posedge clk); #1;
      mem_ack = 1'b0; cpu_req = 1'b0;
      check("back_idle", 32'(dbg_state), 32'(IDLE));
    end else begin
      exp_q.delete();
      do_reset();
    end
  endtask

  initial begin
    vec_t v;
    mem_m[32'h010] = 32'hDEAD_BEEF;
    // set 0: cold miss, hit, LRU eviction, write-through hit and write miss
    add(0, 32'h010, 0, 3, 0, 0);
    add(0, 32'h010, 0, 0, 1, 0);
    add(0, 32'h000, 0, 1, 0, 0);
    add(0, 32'h000, 0, 0, 1, 0);
    add(0, 32'h020, 0, 2, 0, 0);
    add(0, 32'h000, 0, 0, 1, 0);
    add(0, 32'h010, 0, 1, 0, 0);
    add(1, 32'h010, 32'h1234_5678, 2, 1, 0);
    add(0, 32'h010, 0, 0, 1, 0);
    add(1, 32'h030, $urandom, 1, 0, 0);
    add(0, 32'h030, 0, 2, 0, 0);
    add(0, 32'h010, 0, 0, 1, 0);
    add(0, 32'h020, 0, 1, 0, 0);
    // set 1: alternating LRU victims
    add(0, 32'h004, 0, 1, 0, 0);
    add(0, 32'h104, 0, 2, 0, 0);
    add(0, 32'h004, 0, 0, 1, 0);
    add(0, 32'h204, 0, 1, 0, 0);
    add(0, 32'h104, 0, 1, 0, 0);
    add(0, 32'h204, 0, 0, 1, 0);
    add(0, 32'h004, 0, 1, 0, 0);
    // set 3: write miss, refill, write hit, byte offset ignored
    add(1, 32'h00C, $urandom, 1, 0, 0);
    add(0, 32'h00C, 0, 2, 0, 0);
    add(1, 32'h00C, $urandom, 1, 1, 0);
    add(0, 32'h00E, 0, 0, 1, 0);
    // set 2: cpu_req dropped mid-transaction, random memory latency
    add(0, 32'h108, 0, $urandom_range(2, 4), 0, 1);
    add(0, 32'h108, 0, 0, 1, 0);
    add(1, 32'h208, $urandom, 2, 0, 1);
    add(0, 32'h208, 0, $urandom_range(1, 3), 0, 0);

    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h010; cpu_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    #3;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    cpu_req = 1'b1;
    #1;
    check("rst_hit", 32'(hit), 32'd0);
    check("rst_ready_req", 32'(cpu_ready), 32'd0);
    cpu_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) access(vecs[i]);

    // mem_ack and an unrequested cached address in IDLE must change nothing
    do_reset();
    add(0, 32'h048, 0, 1, 0, 0);
    access(vecs[vecs.size()-1]);
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_addr = 32'h048; mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    check("idle_ack_ready", 32'(cpu_ready), 32'd0);
    check("idle_ack_mem_req", 32'(mem_req), 32'd0);
    check("idle_hit", 32'(hit), 32'd1);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    check("idle_ack_state", 32'(dbg_state), 32'(IDLE));
    add(0, 32'h048, 0, 0, 1, 0);
    access(vecs[vecs.size()-1]);

    // reset in the middle of a refill
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h088;
    @(posedge clk); #1;
    @(negedge clk);
    check("refill_mem_req", 32'(mem_req), 32'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("rstmid_mem_req", 32'(mem_req), 32'd0);
    check("rstmid_state", 32'(dbg_state), 32'(IDLE));
    check("rstmid_ready", 32'(cpu_ready), 32'd0);
    cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    v.we = 0; v.addr = 32'h088; v.wdata = '0; v.dly = 2; v.exp_hit = 0; v.drop = 0;
    access(v);
    v.addr = 32'h048; v.dly = 1;
    access(v);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of address and data words.
REQ-002 Parameter SET_WIDTH, default 2: index bits; 2**SET_WIDTH sets, 2 ways, one word per line.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 cpu_req  in  1  CPU access request; cpu_we/addr/wdata are held stable by the CPU until cpu_ready.
REQ-006 cpu_we  in  1  1 = write, 0 = read.
REQ-007 cpu_addr  in  DATA_WIDTH  byte address; tag = [31:4], index = [3:2], [1:0] ignored.
REQ-008 cpu_wdata  in  DATA_WIDTH  store data.
REQ-009 cpu_rdata  out  DATA_WIDTH  load data, valid when cpu_ready=1 and cpu_we=0.
REQ-010 cpu_ready  out  1  access completes this cycle; CPU stalls while cpu_req=1 and cpu_ready=0.
REQ-011 hit  out  1  combinational tag match (either way, valid) for the current cpu_addr.
REQ-012 mem_req  out  1  main-memory request, held until mem_ack.
REQ-013 mem_we  out  1  main-memory write.
REQ-014 mem_addr  out  DATA_WIDTH  word-aligned address (cpu_addr with [1:0]=0).
REQ-015 mem_wdata  out  DATA_WIDTH  equals cpu_wdata during writes.
REQ-016 mem_rdata  in  DATA_WIDTH  refill data, valid with mem_ack.
REQ-017 mem_ack  in  1  one-cycle completion pulse from memory.

Function
REQ-018 The FSM SHALL have states IDLE, REFILL and WRITE; no other states.
REQ-019 IDLE, read hit: cpu_ready=1 in the same cycle, cpu_rdata from the hitting way, LRU updated at the next edge; the FSM stays in IDLE.
REQ-020 IDLE, read miss: cpu_ready=0, next state REFILL; mem_req=1, mem_we=0 from the first REFILL cycle.
REQ-021 REFILL with mem_ack=1: cpu_ready=1 and cpu_rdata=mem_rdata that cycle; the victim line is written {valid=1, tag, mem_rdata} at the edge; next state IDLE.
REQ-022 Victim selection: first invalid way (way 0 if both are invalid), else the LRU way.
REQ-023 IDLE, any write: next state WRITE (write-through, no write-allocate); on a hit, that way's data is updated with cpu_wdata and LRU is updated at the entry edge.
REQ-024 WRITE: mem_req=1, mem_we=1 until mem_ack; cpu_ready=1 in the mem_ack cycle; next state IDLE; a write miss leaves the arrays unchanged.
REQ-025 Per-set LRU bit SHALL point to the way not most recently accessed (hit or refill).
REQ-026 A match in both ways SHALL give way 1 priority for read data and LRU update.
REQ-027 mem_ack in IDLE SHALL be ignored; mem_req never asserts in IDLE.
REQ-028 A transaction, once left IDLE, SHALL complete even if cpu_req drops.
REQ-029 mem_ack arriving on the first REFILL or WRITE cycle SHALL be accepted; no minimum latency is required.
REQ-030 cpu_req=0 in IDLE: cpu_ready=0, no state change, no array update.

Reset
REQ-031 rst SHALL force, asynchronously, state=IDLE, all valid bits=0, all LRU bits=0, mem_req=0, mem_we=0, cpu_ready=0.
REQ-032 rst mid-REFILL or mid-WRITE SHALL abandon the transaction, drop mem_req immediately and write no line.
REQ-033 Tag and data arrays need not be reset.

Structure
REQ-034 Package cache_pkg SHALL hold the state enum (IDLE, REFILL, WRITE), TAG_W=28, IDX_W=SET_WIDTH and the line struct {valid, tag, data}.
REQ-035 One sub-module, cache_way (valid/tag/data storage for one way, combinational read, clocked write), SHALL be instantiated twice; the FSM and LRU bits SHALL be in cache_ctrl.

Verification
REQ-036 Cold read 0x00000010, mem acks after 3 cycles with 0xDEADBEEF -> hit=0, mem_req is high for 3 cycles, cpu_ready and rdata=0xDEADBEEF in the ack cycle.
REQ-037 Repeat read 0x00000010 -> hit=1, cpu_ready=1 in the same cycle, rdata=0xDEADBEEF, mem_req stays 0.
REQ-038 Fill set 0 with 0x000, 0x010, read 0x000, then miss 0x020 -> way holding 0x010 is evicted; 0x000 still hits.
REQ-039 Write 0x12345678 to a cached 0x010 -> mem_we=1, mem_addr=0x010 until ack; a later read hits with 0x12345678. A write to uncached 0x030 -> later read misses.
REQ-040 Assert rst during REFILL -> mem_req=0 immediately, state=IDLE; the next read of the same address misses.
